// File: rtl/vball_gfx_arb.sv
// Two-requester arbiter (background tiles / sprites) for the shared graphics ROM port.
// Phase-dependent priority with starvation override and a watchdog on the memory side.
module vball_gfx_arb #(
    parameter int          ADDR_W  = 19,
    parameter logic [3:0]  STARVE  = 4'd8,
    parameter logic [7:0]  TIMEOUT = 8'd64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              hblank,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    output logic              bg_ack,
    output logic [7:0]        bg_data,
    input  logic              sp_req,
    input  logic [ADDR_W-1:0] sp_addr,
    output logic              sp_ack,
    output logic [7:0]        sp_data,
    output logic              gfx_read,
    output logic [ADDR_W-1:0] gfx_addr,
    input  logic              gfx_ack,
    input  logic [7:0]        gfx_data,
    output logic [7:0]        err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic       OWN_BG  = 1'b0;
    localparam logic       OWN_SP  = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic [3:0]        r_bg_wait;
    logic [3:0]        r_sp_wait;
    logic [7:0]        r_wdog;
    logic              r_gfx_read;
    logic [ADDR_W-1:0] r_gfx_addr;
    logic              r_bg_ack;
    logic              r_sp_ack;
    logic [7:0]        r_bg_data;
    logic [7:0]        r_sp_data;
    logic [7:0]        r_err_cnt;

    logic w_sp_wins;
    logic w_grant;
    logic w_in_txn;
    logic w_timeout;

    // Wait counter update: cleared on grant or idle request, frozen while owning a transaction.
    function automatic logic [3:0] f_next_wait(input logic req, input logic grant,
                                               input logic owns, input logic [3:0] cur);
        logic [3:0] nxt;
        if (grant || !req) begin
            nxt = 4'd0;
        end else if (owns || (cur == 4'hF)) begin
            nxt = cur;
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

    assign w_grant   = (r_state == ST_IDLE) && (bg_req || sp_req);
    assign w_in_txn  = (r_state == ST_BUSY) || (r_state == ST_DONE);
    assign w_timeout = (r_wdog == (TIMEOUT - 8'd1));

    // Winner selection: starvation first (sprite wins a tie), then hblank phase.
    always_comb begin
        w_sp_wins = 1'b0;
        if (bg_req && sp_req) begin
            if (r_sp_wait >= STARVE) begin
                w_sp_wins = 1'b1;
            end else if (r_bg_wait >= STARVE) begin
                w_sp_wins = 1'b0;
            end else begin
                w_sp_wins = hblank;
            end
        end else begin
            w_sp_wins = sp_req;
        end
    end

    // Transaction state machine and memory-side handshake.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_BG;
            r_wdog     <= 8'd0;
            r_gfx_read <= 1'b0;
            r_gfx_addr <= '0;
            r_bg_ack   <= 1'b0;
            r_sp_ack   <= 1'b0;
            r_bg_data  <= 8'd0;
            r_sp_data  <= 8'd0;
            r_err_cnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bg_ack <= 1'b0;
                    r_sp_ack <= 1'b0;
                    if (w_grant) begin
                        r_owner    <= w_sp_wins;
                        r_gfx_addr <= w_sp_wins ? sp_addr : bg_addr;
                        r_gfx_read <= 1'b1;
                        r_wdog     <= 8'd0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_wdog <= r_wdog + 8'd1;
                    if (gfx_ack || w_timeout) begin
                        if (r_owner == OWN_SP) begin
                            r_sp_data <= gfx_ack ? gfx_data : 8'hFF;
                            r_sp_ack  <= 1'b1;
                        end else begin
                            r_bg_data <= gfx_ack ? gfx_data : 8'hFF;
                            r_bg_ack  <= 1'b1;
                        end
                        if (!gfx_ack && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_gfx_read <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bg_ack <= 1'b0;
                    r_sp_ack <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_bg_ack   <= 1'b0;
                    r_sp_ack   <= 1'b0;
                    r_gfx_read <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-requester starvation counters.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bg_wait <= 4'd0;
            r_sp_wait <= 4'd0;
        end else begin
            r_bg_wait <= f_next_wait(bg_req, w_grant && !w_sp_wins,
                                     w_in_txn && (r_owner == OWN_BG), r_bg_wait);
            r_sp_wait <= f_next_wait(sp_req, w_grant && w_sp_wins,
                                     w_in_txn && (r_owner == OWN_SP), r_sp_wait);
        end
    end

    assign gfx_read = r_gfx_read;
    assign gfx_addr = r_gfx_addr;
    assign bg_ack   = r_bg_ack;
    assign bg_data  = r_bg_data;
    assign sp_ack   = r_sp_ack;
    assign sp_data  = r_sp_data;
    assign err_cnt  = r_err_cnt;

endmodule
